// File: rtl/kgp_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// kgp_ctrl_pkg
// Shared definitions for the KGP-RISC control sequencer:
//   - FSM state encoding
//   - opcode / R-class funct constants
//   - instruction classes and branch-condition codes
//   - ALU control codes driven onto alu_control
//   - kgp_decode(): instruction word -> decoded control bundle
// Instruction format: op[31:26] rs[25:21] rt[20:16] imm[15:0], funct = imm[5:0].
// ----------------------------------------------------------------------------
package kgp_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_HALT
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_LD    = 6'h02;
  localparam logic [5:0] OP_ST    = 6'h03;
  localparam logic [5:0] OP_BR    = 6'h04;
  localparam logic [5:0] OP_BZ    = 6'h05;
  localparam logic [5:0] OP_BNZ   = 6'h06;
  localparam logic [5:0] OP_BCY   = 6'h07;
  localparam logic [5:0] OP_BS    = 6'h08;
  localparam logic [5:0] OP_BV    = 6'h09;
  localparam logic [5:0] OP_BL    = 6'h0A;
  localparam logic [5:0] OP_JR    = 6'h0B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // R-class funct field
  localparam logic [5:0] FN_ADD = 6'h00;
  localparam logic [5:0] FN_SUB = 6'h01;
  localparam logic [5:0] FN_AND = 6'h02;
  localparam logic [5:0] FN_OR  = 6'h03;
  localparam logic [5:0] FN_XOR = 6'h04;
  localparam logic [5:0] FN_SLL = 6'h05;
  localparam logic [5:0] FN_SRL = 6'h06;
  localparam logic [5:0] FN_SRA = 6'h07;

  // ALU control codes; ALU_NONE is what non-ALU instructions present
  localparam logic [5:0] ALU_NONE   = 6'd0;
  localparam logic [5:0] ALU_ADD    = 6'd1;
  localparam logic [5:0] ALU_SUB    = 6'd2;
  localparam logic [5:0] ALU_AND    = 6'd3;
  localparam logic [5:0] ALU_OR     = 6'd4;
  localparam logic [5:0] ALU_XOR    = 6'd5;
  localparam logic [5:0] ALU_SLL    = 6'd6;
  localparam logic [5:0] ALU_SRL    = 6'd7;
  localparam logic [5:0] ALU_SRA    = 6'd8;
  localparam logic [5:0] ALU_PASS_A = 6'd9;

  typedef enum logic [2:0] {
    IC_ILLEGAL,
    IC_ALU,
    IC_LD,
    IC_ST,
    IC_BRANCH,
    IC_BL,
    IC_JR,
    IC_HALT
  } iclass_t;

  typedef enum logic [2:0] {
    BC_ALWAYS,
    BC_ZERO,
    BC_NZERO,
    BC_CARRY,
    BC_SIGN,
    BC_OVF
  } bcond_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic sign;
    logic overflow;
  } flags_t;

  typedef struct packed {
    iclass_t    iclass;
    logic [5:0] alu_op;
    bcond_t     bcond;
    logic       const_src;
    logic       is_shift;
  } decoded_t;

  function automatic decoded_t kgp_decode(input logic [31:0] ir);
    decoded_t d;
    d.iclass    = IC_ILLEGAL;
    d.alu_op    = ALU_NONE;
    d.bcond     = BC_ALWAYS;
    d.const_src = 1'b0;
    d.is_shift  = 1'b0;
    case (ir[31:26])
      OP_RTYPE: begin
        d.iclass = IC_ALU;
        case (ir[5:0])
          FN_ADD:  d.alu_op = ALU_ADD;
          FN_SUB:  d.alu_op = ALU_SUB;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_XOR:  d.alu_op = ALU_XOR;
          FN_SLL:  begin d.alu_op = ALU_SLL; d.is_shift = 1'b1; end
          FN_SRL:  begin d.alu_op = ALU_SRL; d.is_shift = 1'b1; end
          FN_SRA:  begin d.alu_op = ALU_SRA; d.is_shift = 1'b1; end
          default: d.iclass = IC_ILLEGAL;
        endcase
      end
      OP_ADDI: begin d.iclass = IC_ALU; d.alu_op = ALU_ADD; d.const_src = 1'b1; end
      OP_LD:   begin d.iclass = IC_LD;  d.alu_op = ALU_ADD; d.const_src = 1'b1; end
      OP_ST:   begin d.iclass = IC_ST;  d.alu_op = ALU_ADD; d.const_src = 1'b1; end
      OP_BR:   begin d.iclass = IC_BRANCH; d.bcond = BC_ALWAYS; end
      OP_BZ:   begin d.iclass = IC_BRANCH; d.bcond = BC_ZERO;   end
      OP_BNZ:  begin d.iclass = IC_BRANCH; d.bcond = BC_NZERO;  end
      OP_BCY:  begin d.iclass = IC_BRANCH; d.bcond = BC_CARRY;  end
      OP_BS:   begin d.iclass = IC_BRANCH; d.bcond = BC_SIGN;   end
      OP_BV:   begin d.iclass = IC_BRANCH; d.bcond = BC_OVF;    end
      OP_BL:   d.iclass = IC_BL;
      OP_JR:   begin d.iclass = IC_JR; d.alu_op = ALU_PASS_A; end
      OP_HALT: d.iclass = IC_HALT;
      default: d.iclass = IC_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/kgp_branch_eval.sv
// ----------------------------------------------------------------------------
// kgp_branch_eval
// Combinational branch decision from a condition code and the saved flags.
//   cond  [2:0] in  : bcond_t code
//   flags [3:0] in  : {zero, carry, sign, overflow} from the flag register
//   taken       out : branch condition satisfied
// ----------------------------------------------------------------------------
module kgp_branch_eval
  import kgp_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  flags_t f;
  assign f = flags_t'(flags);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    taken = 1'b0;
    case (bcond_t'(cond))
      BC_ALWAYS: taken = 1'b1;
      BC_ZERO:   taken = f.zero;
      BC_NZERO:  taken = ~f.zero;
      BC_CARRY:  taken = f.carry;
      BC_SIGN:   taken = f.sign;
      BC_OVF:    taken = f.overflow;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/kgp_control_sequencer.sv
// ----------------------------------------------------------------------------
// kgp_control_sequencer
// Multi-cycle, non-pipelined control FSM for the KGP-RISC data path. Fetches
// from instruction memory, decodes, drives all data_path controls and owns PC.
//
// Parameters: RESET_PC (PC after reset), MEM_WAIT (MEM cycles, 1..7)
// Ports:
//   clk, rst (async, active-low)
//   imem_req/imem_addr out, imem_ack/imem_data in : fetch handshake
//   alu_result, zero/carry/sign/overflow_flag in   : data_path feedback
//   regWriteEnable, reg_to_pc, regWrite_select, MemRead, MemWrite,
//   const_src, reg_data, regAddr_1/2, alu_control, imm, shift_amount out
//   npc, pc, halted out
// Optional build macro KGP_PERF_CNT_EN adds cycle_count and instr_retired.
// ----------------------------------------------------------------------------
module kgp_control_sequencer
  import kgp_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic [31:0] alu_result,
  input  logic        zero_flag,
  input  logic        carry_flag,
  input  logic        sign_flag,
  input  logic        overflow_flag,
  output logic        regWriteEnable,
  output logic        reg_to_pc,
  output logic        regWrite_select,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        const_src,
  output logic        reg_data,
  output logic [4:0]  regAddr_1,
  output logic [4:0]  regAddr_2,
  output logic [5:0]  alu_control,
  output logic [15:0] imm,
  output logic [15:0] shift_amount,
  output logic [31:0] npc,
  output logic [31:0] pc,
  output logic        halted
`ifdef KGP_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_retired
`endif
);

  localparam logic [2:0] MEM_LAST = 3'(MEM_WAIT - 1);

  state_t      state, state_nx;
  logic        started;      // keeps imem_req low for the first cycle after reset release
  logic [31:0] ir;
  flags_t      flag_q;
  logic [2:0]  mem_cnt;
  logic        pc_load;
  logic [31:0] pc_nx;
  logic [31:0] br_target;
  logic        br_taken;
  logic        fetch_fire;
  decoded_t    dec;

  assign dec        = kgp_decode(ir);
  assign fetch_fire = (state == S_FETCH) && started && imem_ack;
  assign br_target  = npc + {{14{ir[15]}}, ir[15:0], 2'b00};
  assign imem_addr  = pc;

  kgp_branch_eval u_branch_eval (
    .cond  (dec.bcond),
    .flags (flag_q),
    .taken (br_taken)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      started <= 1'b0;
      pc      <= RESET_PC;
      npc     <= 32'h0;
      ir      <= 32'h0;
      flag_q  <= '0;
      mem_cnt <= '0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
      if (fetch_fire) begin
        ir  <= imem_data;
        npc <= pc + 32'd4;
      end
      if (pc_load) pc <= pc_nx;
      // Only ALU-class results feed later conditional branches.
      if (state == S_EXEC && dec.iclass == IC_ALU)
        flag_q <= '{zero: zero_flag, carry: carry_flag, sign: sign_flag, overflow: overflow_flag};
      if (state == S_MEM) mem_cnt <= mem_cnt + 3'd1;
      else                mem_cnt <= '0;
    end
  end

  always_comb begin
    state_nx = state;
    pc_load  = 1'b0;
    pc_nx    = npc;
    case (state)
      S_FETCH:  if (fetch_fire) state_nx = S_DECODE;
      S_DECODE: begin
        case (dec.iclass)
          IC_ILLEGAL: begin state_nx = S_FETCH; pc_load = 1'b1; end
          IC_HALT:    state_nx = S_HALT;
          default:    state_nx = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (dec.iclass)
          IC_LD, IC_ST: state_nx = S_MEM;
          IC_ALU:       state_nx = S_WB;
          default:      state_nx = S_BRANCH;
        endcase
      end
      S_MEM:    if (mem_cnt == MEM_LAST) state_nx = S_WB;
      S_WB:     begin state_nx = S_FETCH; pc_load = 1'b1; end
      S_BRANCH: begin
        state_nx = S_FETCH;
        pc_load  = 1'b1;
        if (dec.iclass == IC_JR)                     pc_nx = alu_result;
        else if (dec.iclass == IC_BL || br_taken)    pc_nx = br_target;
      end
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Outputs decode straight off the state register, so an async reset clears
  // strobes such as MemWrite/regWriteEnable immediately.
  always_comb begin
    imem_req        = (state == S_FETCH) && started;
    halted          = (state == S_HALT);
    regWriteEnable  = 1'b0;
    reg_to_pc       = 1'b0;
    regWrite_select = 1'b0;
    MemRead         = 1'b0;
    MemWrite        = 1'b0;
    const_src       = 1'b0;
    reg_data        = 1'b0;
    regAddr_1       = 5'd0;
    regAddr_2       = 5'd0;
    alu_control     = ALU_NONE;
    imm             = 16'h0;
    shift_amount    = 16'h0;
    if (state inside {S_EXEC, S_MEM, S_WB, S_BRANCH}) begin
      // BL links into r31 through the rs write port.
      regAddr_1       = (dec.iclass == IC_BL) ? 5'd31 : ir[25:21];
      regAddr_2       = ir[20:16];
      alu_control     = dec.alu_op;
      imm             = ir[15:0];
      shift_amount    = dec.is_shift ? {11'd0, ir[10:6]} : 16'h0;
      const_src       = dec.const_src;
      reg_data        = (dec.iclass == IC_ALU);
      regWrite_select = (dec.iclass == IC_LD);
      reg_to_pc       = (dec.iclass == IC_BL);
    end
    MemRead        = (state == S_MEM) && (dec.iclass == IC_LD);
    MemWrite       = (state == S_MEM) && (dec.iclass == IC_ST);
    regWriteEnable = ((state == S_WB) && (dec.iclass inside {IC_ALU, IC_LD}))
                   || ((state == S_BRANCH) && (dec.iclass == IC_BL));
  end

`ifdef KGP_PERF_CNT_EN
  logic retire;
  assign retire = (state_nx == S_FETCH) && (state inside {S_DECODE, S_WB, S_BRANCH});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count   <= 32'h0;
      instr_retired <= 32'h0;
    end else begin
      if (state != S_HALT) cycle_count <= cycle_count + 32'd1;
      if (retire)          instr_retired <= instr_retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kgp_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_kgp_control_sequencer
// Table of single instructions executed back-to-back through an instruction
// memory responder; each record carries the expected control activity and the
// next fetch address. Hand sequences cover reset, HALT and reset mid-MEM/WB.
// ----------------------------------------------------------------------------
module tb_kgp_control_sequencer;
  import kgp_ctrl_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned MEM_WAIT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] alu_result = 32'h0;
  logic        zero_flag = 1'b0, carry_flag = 1'b0, sign_flag = 1'b0, overflow_flag = 1'b0;
  logic        regWriteEnable, reg_to_pc, regWrite_select, MemRead, MemWrite, const_src, reg_data;
  logic [4:0]  regAddr_1, regAddr_2;
  logic [5:0]  alu_control;
  logic [15:0] imm, shift_amount;
  logic [31:0] npc, pc;
  logic        halted;
`ifdef KGP_PERF_CNT_EN
  logic [31:0] cycle_count, instr_retired;
`endif

  always #5 clk = ~clk;

  kgp_control_sequencer #(.RESET_PC(RESET_PC), .MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_result(alu_result), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .sign_flag(sign_flag), .overflow_flag(overflow_flag),
    .regWriteEnable(regWriteEnable), .reg_to_pc(reg_to_pc), .regWrite_select(regWrite_select),
    .MemRead(MemRead), .MemWrite(MemWrite), .const_src(const_src), .reg_data(reg_data),
    .regAddr_1(regAddr_1), .regAddr_2(regAddr_2), .alu_control(alu_control),
    .imm(imm), .shift_amount(shift_amount), .npc(npc), .pc(pc), .halted(halted)
`ifdef KGP_PERF_CNT_EN
    , .cycle_count(cycle_count), .instr_retired(instr_retired)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flags;     // {zero, carry, sign, overflow} driven during the instruction
    logic [31:0] alu_res;
    int          waits;     // imem wait cycles before ack
    logic [5:0]  e_alu;
    logic [4:0]  e_ra1;
    logic [4:0]  e_ra2;
    logic        e_cs;
    int          e_we;
    int          e_mr;
    int          e_mw;
    logic        e_rd;
    logic        e_rws;
    logic        e_r2pc;
    logic [31:0] e_npc;     // npc seen during the write cycle
    logic [31:0] e_next;    // next fetch address
    logic        e_halt;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sb[$];
  logic [31:0] exp_pc;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic string nm(input int idx, input string s);
    return $sformatf("v%0d_%s", idx, s);
  endfunction

  task automatic wait_fetch(input int idx);
    int n = 0;
    while (!imem_req && n < 50) begin @(negedge clk); n++; end
    check(nm(idx, "fetch_req"), imem_req, 1'b1);
    check(nm(idx, "fetch_addr"), imem_addr, exp_pc);
  endtask

  // Runs one instruction from fetch to the next fetch (or HALT).
  task automatic run_vec(input vec_t v, input int idx);
    vec_t        e;
    int          k, we, mr, mw;
    logic        done;
    logic [5:0]  c_alu;
    logic [4:0]  c_ra1, c_ra2;
    logic        c_cs, c_rd, c_rws, c_r2pc;
    logic [31:0] c_npc;
    wait_fetch(idx);
    {zero_flag, carry_flag, sign_flag, overflow_flag} = v.flags;
    alu_result = v.alu_res;
    repeat (v.waits) @(negedge clk);
    imem_ack  = 1'b1;
    imem_data = v.instr;
    sb.push_back(v);
    @(negedge clk);
    k = 0; we = 0; mr = 0; mw = 0; done = 1'b0;
    c_alu = '0; c_ra1 = '0; c_ra2 = '0; c_cs = 0; c_rd = 0; c_rws = 0; c_r2pc = 0; c_npc = '0;
    while (!done && k < 40) begin
      if (k > 0 && (imem_req || halted)) begin
        done = 1'b1;
      end else begin
        if (k == 0)
          check(nm(idx, "decode_idle"),
                {imem_req, regWriteEnable, MemRead, MemWrite, const_src, alu_control, regAddr_1},
                32'h0);
        if (k == 1) begin
          c_alu = alu_control; c_ra1 = regAddr_1; c_ra2 = regAddr_2; c_cs = const_src;
        end
        if (MemRead)  mr++;
        if (MemWrite) mw++;
        if (regWriteEnable) begin
          we++;
          c_rd = reg_data; c_rws = regWrite_select; c_r2pc = reg_to_pc; c_npc = npc;
        end
        // A stray ack with junk data outside FETCH must be ignored.
        imem_ack  = (k == 0);
        imem_data = 32'hDEAD_BEEF;
        @(negedge clk);
        k++;
      end
    end
    imem_ack = 1'b0;
    check(nm(idx, "completed"), done, 1'b1);
    e = sb.pop_front();
    check(nm(idx, "alu_control"), c_alu, e.e_alu);
    check(nm(idx, "regAddr_1"), c_ra1, e.e_ra1);
    check(nm(idx, "regAddr_2"), c_ra2, e.e_ra2);
    check(nm(idx, "const_src"), c_cs, e.e_cs);
    check(nm(idx, "we_cycles"), we, e.e_we);
    check(nm(idx, "memread_cycles"), mr, e.e_mr);
    check(nm(idx, "memwrite_cycles"), mw, e.e_mw);
    check(nm(idx, "reg_data"), c_rd, e.e_rd);
    check(nm(idx, "regWrite_select"), c_rws, e.e_rws);
    check(nm(idx, "reg_to_pc"), c_r2pc, e.e_r2pc);
    if (e.e_we != 0) check(nm(idx, "npc_at_write"), c_npc, e.e_npc);
    if (e.e_halt) begin
      check(nm(idx, "halted"), halted, 1'b1);
    end else begin
      check(nm(idx, "next_fetch"), imem_addr, e.e_next);
      exp_pc = e.e_next;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_pc = RESET_PC;
  endtask

  // Reset asserted while MemWrite (ST) or regWriteEnable (LD) is active.
  task automatic reset_mid(input logic [31:0] instr, input bit on_we, input int idx);
    vec_t v;
    int   n;
    apply_reset();
    v = '{default: 0};
    v.instr  = enc(6'h2A, 5'd0, 5'd0, 16'h0);   // illegal -> NOP, moves pc off RESET_PC
    v.e_next = RESET_PC + 32'd4;
    run_vec(v, idx);
    wait_fetch(idx + 1);
    imem_ack = 1'b1; imem_data = instr;
    @(negedge clk);
    imem_ack = 1'b0;
    n = 0;
    while (!(on_we ? regWriteEnable : MemWrite) && n < 20) begin @(negedge clk); n++; end
    check(nm(idx + 1, "strobe_seen"), on_we ? regWriteEnable : MemWrite, 1'b1);
    #1 rst = 1'b0;
    #1;
    check(nm(idx + 1, "strobes_drop_async"), {regWriteEnable, MemWrite, MemRead, imem_req}, 32'h0);
    check(nm(idx + 1, "pc_reset_async"), pc, RESET_PC);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check(nm(idx + 1, "refetch_req"), imem_req, 1'b1);
    check(nm(idx + 1, "refetch_addr"), imem_addr, RESET_PC);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef KGP_PERF_CNT_EN
    logic [31:0] cc0;
`endif
    //              instr                                    flags    alu_res      w  alu         ra1    ra2    cs    we mr mw rd    rws   r2pc  npc           next          halt
    vecs.push_back('{enc(OP_RTYPE, 5'd1, 5'd2, {10'd0, FN_ADD}), 4'b0000, 32'h0,      3, ALU_ADD,    5'd1,  5'd2,  1'b0, 1, 0, 0, 1'b1, 1'b0, 1'b0, 32'h4,        32'h4,        1'b0});
    vecs.push_back('{enc(OP_LD, 5'd2, 5'd3, 16'd8),              4'b1000, 32'h0,      0, ALU_ADD,    5'd2,  5'd3,  1'b1, 1, 2, 0, 1'b0, 1'b1, 1'b0, 32'h8,        32'h8,        1'b0});
    vecs.push_back('{enc(OP_ST, 5'd5, 5'd4, 16'd4),              4'b1000, 32'h0,      1, ALU_ADD,    5'd5,  5'd4,  1'b1, 0, 0, 2, 1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        1'b0});
    vecs.push_back('{enc(OP_RTYPE, 5'd6, 5'd7, {10'd0, FN_SUB}), 4'b1000, 32'h0,      0, ALU_SUB,    5'd6,  5'd7,  1'b0, 1, 0, 0, 1'b1, 1'b0, 1'b0, 32'h10,       32'h10,       1'b0});
    vecs.push_back('{enc(OP_BZ, 5'd0, 5'd0, 16'hFFFE),           4'b0000, 32'h0,      0, ALU_NONE,   5'd0,  5'd0,  1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        1'b0});
    vecs.push_back('{enc(OP_RTYPE, 5'd6, 5'd7, {10'd0, FN_SUB}), 4'b0100, 32'h0,      0, ALU_SUB,    5'd6,  5'd7,  1'b0, 1, 0, 0, 1'b1, 1'b0, 1'b0, 32'h10,       32'h10,       1'b0});
    vecs.push_back('{enc(OP_BZ, 5'd0, 5'd0, 16'hFFFE),           4'b1000, 32'h0,      0, ALU_NONE,   5'd0,  5'd0,  1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h14,       1'b0});
    vecs.push_back('{enc(OP_BNZ, 5'd0, 5'd0, 16'h0001),          4'b1000, 32'h0,      0, ALU_NONE,   5'd0,  5'd0,  1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h1C,       1'b0});
    vecs.push_back('{enc(6'h2A, 5'd3, 5'd4, 16'h0055),           4'b0000, 32'h0,      0, ALU_NONE,   5'd0,  5'd0,  1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h20,       1'b0});
    vecs.push_back('{enc(OP_JR, 5'd9, 5'd0, 16'h0),              4'b0000, 32'hFFFF_FFFC, 0, ALU_PASS_A, 5'd9, 5'd0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,      32'hFFFF_FFFC, 1'b0});
    vecs.push_back('{enc(OP_BL, 5'd0, 5'd0, 16'h0),              4'b0000, 32'h0,      0, ALU_NONE,   5'd31, 5'd0,  1'b0, 1, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{enc(OP_HALT, 5'd0, 5'd0, 16'h0),            4'b0000, 32'h0,      0, ALU_NONE,   5'd0,  5'd0,  1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1});

    // Reset held from time 0 through cycle 3.
    repeat (3) @(negedge clk);
    check("reset_pc", pc, RESET_PC);
    check("reset_npc", npc, 32'h0);
    check("reset_outputs", {imem_req, halted, regWriteEnable, reg_to_pc, regWrite_select,
                            MemRead, MemWrite, const_src, reg_data, alu_control, regAddr_1, regAddr_2}, 32'h0);
    check("reset_imm", {imm, shift_amount}, 32'h0);
`ifdef KGP_PERF_CNT_EN
    check("reset_counters", cycle_count | instr_retired, 32'h0);
`endif
    rst = 1'b1;
    #1 check("release_req_not_yet", imem_req, 1'b0);
    @(negedge clk);
    check("release_req", imem_req, 1'b1);
    check("release_addr", imem_addr, RESET_PC);
    exp_pc = RESET_PC;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // HALT is absorbing: no fetch, no controls, ack ignored.
`ifdef KGP_PERF_CNT_EN
    check("retired_before_halt", instr_retired, 32'd11);
    cc0 = cycle_count;
`endif
    imem_ack = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("halt_hold_%0d", c),
            {halted, imem_req, regWriteEnable, MemRead, MemWrite, reg_to_pc, alu_control},
            {1'b1, 5'b0, 6'd0});
    end
    imem_ack = 1'b0;
`ifdef KGP_PERF_CNT_EN
    check("halt_cycle_frozen", cycle_count, cc0);
    check("halt_retired_frozen", instr_retired, 32'd11);
`endif

    reset_mid(enc(OP_ST, 5'd1, 5'd2, 16'd0), 1'b0, 20);
    reset_mid(enc(OP_LD, 5'd2, 5'd3, 16'd8), 1'b1, 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
